// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one req/ack bus transaction per memory instruction,
// store lane alignment, load extraction, pipeline stall. Optional LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] exmemAddr,
    input  logic [31:0] exmemStoreData,
    input  logic [2:0]  exmemStoreLoadSel,
    input  logic        exmemMemRead,
    input  logic        exmemMemWrite,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memWstrb,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        stall,
    output logic [31:0] loadData,
    output logic        busError,
    output logic        misaligned
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic       TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TO_LAST = 8'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t      state, stateNext;
    logic        access, isStore, trap, timeout;
    logic [7:0]  waitCnt;
    logic [2:0]  selLat;
    logic [1:0]  offLat;
    logic        loadLat;
    logic [31:0] wdataAl, loadExt, byteSh, halfSh;
    logic [3:0]  wstrbAl;

    assign access  = exmemMemRead | exmemMemWrite;
    assign isStore = exmemMemWrite;
    assign timeout = TO_EN && (waitCnt == TO_LAST);
    assign stall   = ((state == IDLE) && access) || (state == WAIT);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalignedQ;
    // half needs addr[0]=0; word (sel[1]=1) needs addr[1:0]=0
    assign trap = ((exmemStoreLoadSel[1:0] == 2'b01) && exmemAddr[0]) ||
                  (exmemStoreLoadSel[1] && (exmemAddr[1:0] != 2'b00));
    assign misaligned = misalignedQ;
`else
    assign trap       = 1'b0;
    assign misaligned = 1'b0;
`endif

    always_comb begin
        wdataAl = exmemStoreData;
        wstrbAl = 4'b1111;
        case (exmemStoreLoadSel[1:0])
            2'b00: begin
                wdataAl = {4{exmemStoreData[7:0]}};
                wstrbAl = 4'b0001 << exmemAddr[1:0];
            end
            2'b01: begin
                wdataAl = {2{exmemStoreData[15:0]}};
                wstrbAl = 4'b0011 << {exmemAddr[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Extraction uses the size/offset latched at issue, not the live EX/MEM inputs.
    assign byteSh = memRdata >> {offLat, 3'b000};
    assign halfSh = memRdata >> {offLat[1], 4'b0000};

    always_comb begin
        loadExt = memRdata;
        case (selLat)
            3'b000:  loadExt = {{24{byteSh[7]}}, byteSh[7:0]};
            3'b100:  loadExt = {24'd0, byteSh[7:0]};
            3'b001:  loadExt = {{16{halfSh[15]}}, halfSh[15:0]};
            3'b101:  loadExt = {16'd0, halfSh[15:0]};
            default: loadExt = memRdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (access) stateNext = trap ? DONE : WAIT;
            WAIT:    if (memAck || timeout) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= 32'd0;
            memWdata <= 32'd0;
            memWstrb <= 4'd0;
            busError <= 1'b0;
            loadData <= 32'd0;
            waitCnt  <= 8'd0;
            selLat   <= 3'd0;
            offLat   <= 2'd0;
            loadLat  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalignedQ <= 1'b0;
`endif
        end else begin
            busError <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalignedQ <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (access && trap) begin
                        loadData <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
                        misalignedQ <= 1'b1;
`endif
                    end else if (access) begin
                        memReq   <= 1'b1;
                        memWe    <= isStore;
                        memAddr  <= {exmemAddr[31:2], 2'b00};
                        memWdata <= wdataAl;
                        memWstrb <= isStore ? wstrbAl : 4'b0000;
                        selLat   <= exmemStoreLoadSel;
                        offLat   <= exmemAddr[1:0];
                        loadLat  <= ~isStore;
                        waitCnt  <= 8'd0;
                    end
                end
                WAIT: begin
                    if (memAck) begin
                        memReq <= 1'b0;
                        if (loadLat) loadData <= loadExt;
                    end else if (timeout) begin
                        memReq   <= 1'b0;
                        loadData <= 32'd0;
                        busError <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (TIMEOUT_CYCLES=4); one task per scenario.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] exmemAddr, exmemStoreData, memRdata;
    logic [2:0]  exmemStoreLoadSel;
    logic        exmemMemRead, exmemMemWrite, memAck;
    logic        memReq, memWe, stall, busError, misaligned;
    logic [31:0] memAddr, memWdata, loadData;
    logic [3:0]  memWstrb;

    int checks = 0;
    int errors = 0;

    // observations from the last runAccess
    int          obsStall, obsReq;
    logic        obsStable, obsDone, obsBusErr, obsMis, obsReqInDone, obsWe;
    logic [31:0] obsAddr, obsWdata, obsLoad;
    logic [3:0]  obsWstrb;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .exmemAddr(exmemAddr), .exmemStoreData(exmemStoreData),
        .exmemStoreLoadSel(exmemStoreLoadSel),
        .exmemMemRead(exmemMemRead), .exmemMemWrite(exmemMemWrite),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memWstrb(memWstrb), .memAck(memAck), .memRdata(memRdata),
        .stall(stall), .loadData(loadData), .busError(busError), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    // Drives one access, acks after ackDelay WAIT cycles (-1 = never), records what it saw.
    task automatic runAccess(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                             input logic rd, input logic wr, input int ackDelay,
                             input logic [31:0] rdata);
        int waitIdx;
        waitIdx = 0; obsStall = 0; obsReq = 0; obsStable = 1'b1; obsDone = 1'b0;
        @(negedge clk);
        exmemAddr = a; exmemStoreData = d; exmemStoreLoadSel = s;
        exmemMemRead = rd; exmemMemWrite = wr; memAck = 1'b0; memRdata = rdata;
        #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0 && !stall) begin
                obsDone = 1'b1; obsLoad = loadData; obsBusErr = busError;
                obsMis = misaligned; obsReqInDone = memReq;
                break;
            end
            if (stall) obsStall++;
            if (memReq) begin
                if (obsReq == 0) begin
                    obsAddr = memAddr; obsWdata = memWdata; obsWstrb = memWstrb; obsWe = memWe;
                end else if (memAddr !== obsAddr || memWdata !== obsWdata ||
                             memWstrb !== obsWstrb || memWe !== obsWe) begin
                    obsStable = 1'b0;
                end
                obsReq++;
            end
            memAck = memReq && (ackDelay >= 0) && (waitIdx == ackDelay);
            if (memReq) waitIdx++;
            @(negedge clk); #1;
        end
        memAck = 1'b0; exmemMemRead = 1'b0; exmemMemWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; memAck = 1'b0; memRdata = 32'd0; exmemAddr = 32'd0;
        exmemStoreData = 32'd0; exmemStoreLoadSel = 3'd0;
        exmemMemRead = 1'b0; exmemMemWrite = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; #1;
        checks++;
        if (memReq !== 1'b0 || memWe !== 1'b0 || memWstrb !== 4'd0 || memAddr !== 32'd0 ||
            memWdata !== 32'd0 || loadData !== 32'd0 || busError !== 1'b0 ||
            misaligned !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset: req=%b we=%b strb=%h addr=%h wd=%h ld=%h be=%b mis=%b stall=%b, all zero required",
                     memReq, memWe, memWstrb, memAddr, memWdata, loadData, busError, misaligned, stall);
        end
    endtask

    task automatic test_sw();
        runAccess(32'h1004, 32'hDEADBEEF, 3'b010, 1'b0, 1'b1, 0, 32'd0);
        checks++;
        if (!obsDone || obsAddr !== 32'h1004 || obsWstrb !== 4'b1111 ||
            obsWdata !== 32'hDEADBEEF || obsWe !== 1'b1) begin
            errors++;
            $display("FAIL sw_bus: done=%b addr=%h strb=%b wd=%h we=%b, need 1 00001004 1111 deadbeef 1",
                     obsDone, obsAddr, obsWstrb, obsWdata, obsWe);
        end
        checks++;
        if (obsStall != 2 || obsReq != 1 || obsReqInDone !== 1'b0) begin
            errors++;
            $display("FAIL sw_timing: stall=%0d req=%0d reqInDone=%b, need 2 1 0", obsStall, obsReq, obsReqInDone);
        end
        @(negedge clk); #1;
        checks++;
        if (stall !== 1'b0 || memReq !== 1'b0) begin
            errors++;
            $display("FAIL sw_idle: stall=%b req=%b, need 0 0", stall, memReq);
        end
    endtask

    task automatic test_sb();
        // read+write together must behave as a store
        runAccess(32'h2003, 32'h000000A5, 3'b000, 1'b1, 1'b1, 0, 32'd0);
        checks++;
        if (!obsDone || obsAddr !== 32'h2000 || obsWstrb !== 4'b1000 ||
            obsWdata !== 32'hA5A5A5A5 || obsWe !== 1'b1) begin
            errors++;
            $display("FAIL sb_bus: done=%b addr=%h strb=%b wd=%h we=%b, need 1 00002000 1000 a5a5a5a5 1",
                     obsDone, obsAddr, obsWstrb, obsWdata, obsWe);
        end
    endtask

    task automatic test_lb();
        runAccess(32'h3002, 32'd0, 3'b000, 1'b1, 1'b0, 3, 32'h0080FF00);
        checks++;
        if (!obsDone || obsLoad !== 32'hFFFFFF80 || obsBusErr !== 1'b0) begin
            errors++;
            $display("FAIL lb_data: done=%b ld=%h be=%b, need 1 ffffff80 0", obsDone, obsLoad, obsBusErr);
        end
        checks++;
        if (obsReq != 4 || !obsStable || obsStall != 5 || obsWe !== 1'b0 ||
            obsWstrb !== 4'd0 || obsAddr !== 32'h3000) begin
            errors++;
            $display("FAIL lb_bus: req=%0d stable=%b stall=%0d we=%b strb=%b addr=%h, need 4 1 5 0 0000 00003000",
                     obsReq, obsStable, obsStall, obsWe, obsWstrb, obsAddr);
        end
        runAccess(32'h3002, 32'd0, 3'b100, 1'b1, 1'b0, 3, 32'h0080FF00);
        checks++;
        if (!obsDone || obsLoad !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu_data: done=%b ld=%h, need 1 00000080", obsDone, obsLoad);
        end
    endtask

    task automatic test_lh();
        runAccess(32'h4002, 32'd0, 3'b001, 1'b1, 1'b0, 1, 32'h80011234);
        checks++;
        if (!obsDone || obsLoad !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL lh_data: done=%b ld=%h, need 1 ffff8001", obsDone, obsLoad);
        end
        runAccess(32'h4002, 32'd0, 3'b101, 1'b1, 1'b0, 0, 32'h80011234);
        checks++;
        if (!obsDone || obsLoad !== 32'h00008001) begin
            errors++;
            $display("FAIL lhu_data: done=%b ld=%h, need 1 00008001", obsDone, obsLoad);
        end
    endtask

    task automatic test_sh_keeps_load();
        runAccess(32'h4002, 32'h1234ABCD, 3'b101, 1'b0, 1'b1, 0, 32'hFFFFFFFF);
        checks++;
        if (obsWdata !== 32'hABCDABCD || obsWstrb !== 4'b1100 || obsAddr !== 32'h4000) begin
            errors++;
            $display("FAIL sh_bus: wd=%h strb=%b addr=%h, need abcdabcd 1100 00004000", obsWdata, obsWstrb, obsAddr);
        end
        checks++;
        if (obsLoad !== 32'h00008001) begin
            errors++;
            $display("FAIL store_keeps_load: ld=%h, need 00008001", obsLoad);
        end
    endtask

    task automatic test_ack_idle();
        @(negedge clk);
        memAck = 1'b1; memRdata = 32'h55555555;
        @(negedge clk); #1;
        memAck = 1'b0;
        checks++;
        if (memReq !== 1'b0 || stall !== 1'b0 || loadData !== 32'h00008001) begin
            errors++;
            $display("FAIL ack_idle: req=%b stall=%b ld=%h, need 0 0 00008001", memReq, stall, loadData);
        end
    endtask

    task automatic test_timeout();
        runAccess(32'h6000, 32'd0, 3'b010, 1'b1, 1'b0, -1, 32'h12345678);
        checks++;
        if (!obsDone || obsBusErr !== 1'b1 || obsLoad !== 32'd0) begin
            errors++;
            $display("FAIL timeout_done: done=%b be=%b ld=%h, need 1 1 00000000", obsDone, obsBusErr, obsLoad);
        end
        checks++;
        if (obsReq != 4 || obsStall != 5 || obsReqInDone !== 1'b0) begin
            errors++;
            $display("FAIL timeout_len: req=%0d stall=%0d reqInDone=%b, need 4 5 0", obsReq, obsStall, obsReqInDone);
        end
        @(negedge clk); #1;
        checks++;
        if (busError !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: be=%b after DONE, need 0", busError);
        end
    endtask

    task automatic test_reset_in_wait();
        runAccess(32'h7000, 32'd0, 3'b100, 1'b1, 1'b0, 0, 32'h000000C3);
        @(negedge clk);
        exmemAddr = 32'h7000; exmemStoreLoadSel = 3'b010; exmemMemRead = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (memReq !== 1'b1 || loadData !== 32'h000000C3) begin
            errors++;
            $display("FAIL rstwait_pre: req=%b ld=%h, need 1 000000c3", memReq, loadData);
        end
        rst = 1'b1; exmemMemRead = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (memReq !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_req: req=%b, need 0", memReq);
        end
        rst = 1'b0; memAck = 1'b1; memRdata = 32'h12345678;
        @(negedge clk); #1;
        memAck = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (memReq !== 1'b0 || loadData !== 32'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_ack: req=%b ld=%h stall=%b, need 0 00000000 0", memReq, loadData, stall);
        end
    endtask

    task automatic test_misaligned_word();
        runAccess(32'h5002, 32'd0, 3'b010, 1'b1, 1'b0, 0, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if (!obsDone || obsReq != 0 || obsStall != 1 || obsMis !== 1'b1 || obsLoad !== 32'd0) begin
            errors++;
            $display("FAIL misalign_trap: done=%b req=%0d stall=%0d mis=%b ld=%h, need 1 0 1 1 00000000",
                     obsDone, obsReq, obsStall, obsMis, obsLoad);
        end
`else
        checks++;
        if (!obsDone || obsReq != 1 || obsAddr !== 32'h5000 || obsMis !== 1'b0 ||
            obsLoad !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL misalign_word: done=%b req=%0d addr=%h mis=%b ld=%h, need 1 1 00005000 0 cafef00d",
                     obsDone, obsReq, obsAddr, obsMis, obsLoad);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb();
        test_lb();
        test_lh();
        test_sh_keeps_load();
        test_ack_idle();
        test_timeout();
        test_misaligned_word();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
